// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state type and stream byte-count constants for imem_loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE} state_t;
  localparam int LEN_BYTES = 2;
  localparam int CHK_BYTES = 1;
  localparam int WORD_BYTES = 4;
  localparam int LEN_W = 8 * LEN_BYTES;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed little-endian byte stream into instruction memory
//   clk, reset_n (async active-low)        start: begin a session (IDLE only)
//   in_data/in_valid/in_ready: byte stream  mem_we/mem_addr/mem_wdata: word write port
//   busy: not IDLE (holds CPU in reset)     done: end-of-session pulse   err: sticky error
//   Optional macro IMEM_LOADER_CHKSUM_EN adds a trailing checksum byte (CHK state).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int DEPTH = 2 ** ADDR_W;
  state_t state, nxt;
  logic [LEN_W-1:0] len, n_len;
  logic [1:0] bcnt;
  logic [ADDR_W:0] idx;
  logic acc, last_word, len_bad;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [8*CHK_BYTES-1:0] sum;
  assign in_ready = state inside {LEN0, LEN1, DATA, CHK};
`else
  assign in_ready = state inside {LEN0, LEN1, DATA};
`endif
  assign acc = in_valid && in_ready;
  assign n_len = {in_data, len[7:0]};
  assign len_bad = int'(n_len) > DEPTH;
  // idx is the index of the word being written; idx+1 words are done after WRITE
  assign last_word = int'(idx) + 1 >= int'(len);
  assign mem_we = state == WRITE;
  assign mem_addr = idx[ADDR_W-1:0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? LEN0 : IDLE;
      LEN0:  nxt = acc ? LEN1 : LEN0;
      LEN1:  nxt = !acc ? LEN1 : (n_len == '0 || len_bad) ? DONE : DATA;
      DATA:  nxt = (acc && bcnt == 2'(WORD_BYTES - 1)) ? WRITE : DATA;
`ifdef IMEM_LOADER_CHKSUM_EN
      WRITE: nxt = last_word ? CHK : DATA;
      CHK:   nxt = acc ? DONE : CHK;
`else
      WRITE: nxt = last_word ? DONE : DATA;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      len <= '0;
      bcnt <= '0;
      idx <= '0;
      mem_wdata <= '0;
      err <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        bcnt <= '0;
        idx <= '0;
        err <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
        sum <= '0;
`endif
      end
      if (acc && state == LEN0) len[7:0] <= in_data;
      if (acc && state == LEN1) len[15:8] <= in_data;
      if (acc && state == LEN1 && len_bad) err <= 1'b1;
      // first byte ends up in [7:0] after four right-shifts
      if (acc && state == DATA) begin
        mem_wdata <= {in_data, mem_wdata[31:8]};
        bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
        sum <= sum + in_data;
`endif
      end
      if (state == WRITE) idx <= idx + 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
      if (acc && state == CHK && 8'(sum + in_data) != 8'h00) err <= 1'b1;
`endif
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH = 256;
  logic clk = 0, reset_n = 0, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, mem_we, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  typedef struct packed {logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t wq[$];
  bit dq[$];
  int errors = 0, checks = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t w;
    if (reset_n) begin
      if (mem_we) begin
        chk("in_ready_in_write", in_ready, 0);
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h with no write expected", mem_addr, mem_wdata);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.a);
          chk("wr_data", mem_wdata, w.d);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done pulse with none expected");
        end else chk("done_err", err, dq.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      in_valid = 0; in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1; in_data = b;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %0h", b);
    end
    @(posedge clk); #1;
    in_valid = 0; in_data = 8'($urandom);
  endtask

  function automatic bit pick_gap(input int mode, input int k);
    return mode == 1 ? 1'b1 : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // n words from data (4 bytes each, little-endian); ck<0 means send the correct checksum
  task automatic session(input int n, input logic [7:0] data[$], input int mode, input int ck);
    logic [7:0] sum = 0, ckb;
    int t = 0;
    start = 1; @(posedge clk); #1; start = 0;
    chk("start_clears_err", err, 0);
    chk("busy_in_session", busy, 1);
    if (n == 0 || n > DEPTH) begin
      dq.push_back(n > DEPTH);
      send(8'(n), pick_gap(mode, 0));
      send(8'(n >> 8), pick_gap(mode, 1));
      chk("done_after_len", done, 1);
    end else begin
      for (int i = 0; i < n; i++)
        wq.push_back({8'(i), data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]});
      for (int i = 0; i < 4 * n; i++) sum += data[i];
`ifdef IMEM_LOADER_CHKSUM_EN
      ckb = ck < 0 ? 8'(-sum) : 8'(ck);
      dq.push_back(8'(sum + ckb) != 0);
`else
      ckb = 8'(ck);
      dq.push_back(1'b0);
`endif
      send(8'(n), pick_gap(mode, 0));
      send(8'(n >> 8), pick_gap(mode, 1));
      for (int i = 0; i < 4 * n; i++) send(data[i], pick_gap(mode, i));
`ifdef IMEM_LOADER_CHKSUM_EN
      send(ckb, pick_gap(mode, 0));
`endif
    end
    while ((dq.size() > 0 || wq.size() > 0) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (dq.size() > 0 || wq.size() > 0) begin
      checks++; errors++;
      $display("FAIL session_timeout: %0d writes and %0d done pulses outstanding", wq.size(), dq.size());
      wq.delete(); dq.delete();
    end
    @(posedge clk); #1;
    chk("idle_after_done", busy, 0);
  endtask

  task automatic check_reset_state();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
  endtask

  initial begin
    logic [7:0] d[$];
    int n;
    #1 check_reset_state();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;
    chk("idle_ignores_no_start", busy, 0);
    d = {8'h33, 8'h02, 8'h11, 8'h00, 8'hB3, 8'h02, 8'h11, 8'h40};
    session(2, d, 0, -1);
    session(0, d, 0, -1);
    session(257, d, 0, -1);
    session(2, d, 0, -1);
    session(2, d, 1, -1);
    start = 1; @(posedge clk); #1; start = 0;
    send(8'h01, 0); send(8'h00, 0); send(8'h33, 0); send(8'h02, 0);
    #2 reset_n = 0;
    #1 check_reset_state();
    @(posedge clk); #1 reset_n = 1;
    d = {8'h33, 8'h02, 8'h11, 8'h00};
    session(1, d, 0, -1);
`ifdef IMEM_LOADER_CHKSUM_EN
    session(1, d, 0, 8'hBA);
    session(1, d, 0, 8'h00);
`endif
    d = {};
    for (int i = 0; i < 4 * DEPTH; i++) d.push_back(8'($urandom));
    session(DEPTH, d, 0, -1);
    for (int s = 0; s < 20; s++) begin
      n = $urandom_range(0, 9) == 0 ? $urandom_range(257, 65535) : $urandom_range(1, 8);
      d = {};
      for (int i = 0; i < 4 * 8; i++) d.push_back(8'($urandom));
      session(n, d, 2, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 255)) : -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
